rob_wb_arbiter: RTL and testbench
=================================

Name: rob_wb_arbiter

Overview:
- Arbitrates ROB result writeback between execution units: branch, LS, EX1 and EXMUL1.
- There are NREQ requesters and NPORTS ROB write ports, with NPORTS < NREQ.
- Each requester has a one-entry holding buffer, and grants are issued round-robin.
- Sits between the EX/LS/branch unit outputs and the ROB store interface, and replaces the per-unit direct ROB write wiring.

Parameters:
- NREQ, 4, number of requesting units. Index 0 = branch, 1 = LS, 2 = EX1, 3 = EXMUL1.
- NPORTS, 2, number of ROB write ports (1..NREQ).
- SLOT_W, 4, ROB slot index width.
- DATA_W, 32, result width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (branch mispredict/exception). Drops all buffered results.
- req_valid[NREQ]  in  1  requester i presents a result.
- req_slot[NREQ]  in  SLOT_W  destination ROB slot.
- req_data[NREQ]  in  DATA_W  result value.
- req_ready[NREQ]  out  1  arbiter accepts from requester i this cycle.
- wr_valid[NPORTS]  out  1  ROB write port p active.
- wr_slot[NPORTS]  out  SLOT_W  ROB slot for port p.
- wr_data[NPORTS]  out  DATA_W  data for port p.

Behaviour:
- State:
  - buf_full[i], buf_slot[i], buf_data[i] per requester.
  - rr_ptr, width clog2(NREQ).
  - Registered wr_* outputs.
- Reset (synchronous, active-high):
  - buf_full = 0, rr_ptr = 0, wr_valid = 0, wr_slot = 0, wr_data = 0.
  - req_ready reads 1 for all i in the first cycle after reset deasserts.
- Grant (combinational on buffer state and rr_ptr only, never on req_valid):
  - Scan i = rr_ptr, rr_ptr+1, ... mod NREQ.
  - Grant the first up-to-NPORTS requesters with buf_full = 1.
  - The k-th grant in scan order maps to write port k. Ports beyond the grant count are idle.
- Handshake:
  - req_ready[i] = ~buf_full[i] | grant[i].
  - Transfer occurs when req_valid & req_ready at a clock edge. The buffer loads slot/data and buf_full stays or becomes 1.
  - A granted buffer with no new transfer clears buf_full.
  - This gives a sustained 1 result/cycle per requester when it wins every cycle.
- Outputs:
  - Each edge: wr_valid[p] <= port p granted; wr_slot/wr_data[p] <= granted buffer contents.
  - Ungranted ports: wr_valid = 0, slot/data hold their previous values.
- Latency: handshake at cycle c -> buffer full in c+1 -> granted earliest in c+1 -> wr_valid visible in c+2.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted requester + 1) mod NREQ; otherwise unchanged.
- No starvation: any full buffer is granted within ceil(NREQ/NPORTS) cycles.
- flush (takes precedence over everything except reset):
  - Next edge: all buf_full <= 0 and wr_valid <= 0. Transfers offered in the flush cycle are discarded.
  - req_ready is forced to 1 during flush.
  - rr_ptr is unchanged.
- The ROB always accepts writes; there is no write-port backpressure.
- Two requesters targeting the same slot in one cycle is illegal upstream. The arbiter forwards both without checking.
- Reset mid-operation: buffered results are lost, identical to flush, and rr_ptr also returns to 0.

Optional Feature:
- Macro ROB_WB_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_grants (32 bit): total grants issued; increments by the grant count each cycle.
  - stat_conflicts (32 bit): cycles where the number of full buffers exceeds NPORTS.
- Both counters saturate at 0xFFFFFFFF and clear on reset only, not on flush.
- When not defined, neither port nor counter logic exists, and all other behaviour is identical.

Test Plan:
- Reset, then idle -> wr_valid all 0, req_ready all 1, no writes for 10 cycles.
- Single transfer on requester 2 (slot 5, data 0xDEADBEEF) in cycle 3 -> wr_valid[0]=1, wr_slot[0]=5, wr_data[0]=0xDEADBEEF in cycle 5 only; wr_valid[1]=0.
- rr_ptr=0, all 4 requesters transfer in the same cycle (slots 0..3):
  - Next write cycle: ports 0/1 = slots 0/1.
  - Following cycle: ports 0/1 = slots 2/3.
  - req_ready[2], req_ready[3] stay 0 one extra cycle; rr_ptr ends at 0.
- Requester 1 streams 8 results back-to-back, others idle -> req_ready[1] held 1 throughout, 8 consecutive port-0 writes in order.
- Buffers 0 and 3 full and flush asserted, requester 2 offering in the same cycle -> no wr_valid the next cycle, nothing from requester 2 ever written, req_ready all 1.
- With ROB_WB_ARB_STATS_EN defined, the 4-requester burst above -> stat_grants=4, stat_conflicts=1; both unchanged by a subsequent flush.

Source files
------------

// File: rtl/rob_wb_arbiter.sv
// ROB writeback arbiter: one-entry holding buffer per requester, round-robin grant onto NPORTS write ports.
// Optional statistics counters are enabled with the ROB_WB_ARB_STATS_EN macro.
module rob_wb_arbiter #(
    parameter int NREQ   = 4,
    parameter int NPORTS = 2,
    parameter int SLOT_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [SLOT_W-1:0] req_slot [NREQ],
    input  logic [DATA_W-1:0] req_data [NREQ],
    output logic [NREQ-1:0]   req_ready,
    output logic [NPORTS-1:0] wr_valid,
    output logic [SLOT_W-1:0] wr_slot [NPORTS],
    output logic [DATA_W-1:0] wr_data [NPORTS]
`ifdef ROB_WB_ARB_STATS_EN
    ,
    output logic [31:0]       stat_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GCNT_W = $clog2(NPORTS + 1);
    localparam int FCNT_W = $clog2(NREQ + 1);

    logic [NREQ-1:0]   buf_full_q, buf_full_d;
    logic [SLOT_W-1:0] buf_slot_q [NREQ];
    logic [SLOT_W-1:0] buf_slot_d [NREQ];
    logic [DATA_W-1:0] buf_data_q [NREQ];
    logic [DATA_W-1:0] buf_data_d [NREQ];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NPORTS-1:0] wr_valid_q, wr_valid_d;
    logic [SLOT_W-1:0] wr_slot_q [NPORTS];
    logic [SLOT_W-1:0] wr_slot_d [NPORTS];
    logic [DATA_W-1:0] wr_data_q [NPORTS];
    logic [DATA_W-1:0] wr_data_d [NPORTS];

    logic [NREQ-1:0]   grant;
    logic [NPORTS-1:0] port_vld;
    logic [PTR_W-1:0]  port_sel [NPORTS];
    logic [PTR_W-1:0]  last_idx;
    logic [GCNT_W-1:0] grant_cnt;
    logic [FCNT_W-1:0] full_cnt;

    // Round-robin scan starting at rr_ptr; the k-th full buffer found drives write port k.
    // NOTE: every always_comb output gets a default before any conditional logic so no latch is inferred.
    always_comb begin
        int idx;
        int cnt;
        grant     = '0;
        port_vld  = '0;
        last_idx  = rr_ptr_q;
        full_cnt  = '0;
        cnt       = 0;
        for (int p = 0; p < NPORTS; p++) port_sel[p] = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (buf_full_q[idx]) begin
                full_cnt = full_cnt + 1'b1;
                if (cnt < NPORTS) begin
                    grant[idx]    = 1'b1;
                    port_vld[cnt] = 1'b1;
                    port_sel[cnt] = PTR_W'(idx);
                    last_idx      = PTR_W'(idx);
                    cnt           = cnt + 1;
                end
            end
        end
        grant_cnt = GCNT_W'(cnt);
    end

    assign req_ready = flush ? '1 : (~buf_full_q | grant);

    always_comb begin
        buf_full_d = buf_full_q;
        buf_slot_d = buf_slot_q;
        buf_data_d = buf_data_q;
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = '0;
        wr_slot_d  = wr_slot_q;
        wr_data_d  = wr_data_q;
        if (flush) begin
            buf_full_d = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_full_d[i] = 1'b1;
                    buf_slot_d[i] = req_slot[i];
                    buf_data_d[i] = req_data[i];
                end else if (grant[i]) begin
                    buf_full_d[i] = 1'b0;
                end
            end
            for (int p = 0; p < NPORTS; p++) begin
                if (port_vld[p]) begin
                    wr_valid_d[p] = 1'b1;
                    wr_slot_d[p]  = buf_slot_q[port_sel[p]];
                    wr_data_d[p]  = buf_data_q[port_sel[p]];
                end
            end
            if (|grant) rr_ptr_d = PTR_W'((int'(last_idx) + 1) % NREQ);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_full_q <= '0;
            rr_ptr_q   <= '0;
            wr_valid_q <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                wr_slot_q[p] <= '0;
                wr_data_q[p] <= '0;
            end
        end else begin
            buf_full_q <= buf_full_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_slot_q  <= wr_slot_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // NOTE: buffer payload is qualified by buf_full, so it is left unreset to keep it plain storage.
    always_ff @(posedge clock) begin
        buf_slot_q <= buf_slot_d;
        buf_data_q <= buf_data_d;
    end

    assign wr_valid = wr_valid_q;
    assign wr_slot  = wr_slot_q;
    assign wr_data  = wr_data_q;

`ifdef ROB_WB_ARB_STATS_EN
    logic [31:0] stat_grants_q, stat_grants_d;
    logic [31:0] stat_conflicts_q, stat_conflicts_d;
    logic [32:0] grants_sum;

    // Grants suppressed by flush never reach a port, so they are not counted.
    always_comb begin
        grants_sum       = {1'b0, stat_grants_q} + (flush ? 33'd0 : 33'(grant_cnt));
        stat_grants_d    = grants_sum[32] ? 32'hFFFF_FFFF : grants_sum[31:0];
        stat_conflicts_d = stat_conflicts_q;
        if ((int'(full_cnt) > NPORTS) && (stat_conflicts_q != 32'hFFFF_FFFF))
            stat_conflicts_d = stat_conflicts_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_grants_q    <= '0;
            stat_conflicts_q <= '0;
        end else begin
            stat_grants_q    <= stat_grants_d;
            stat_conflicts_q <= stat_conflicts_d;
        end
    end

    assign stat_grants    = stat_grants_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: reset/idle, single write, 4-way burst, streaming, flush.
// Statistics checks are compiled in when ROB_WB_ARB_STATS_EN is defined.
module tb_rob_wb_arbiter;

    localparam int NREQ   = 4;
    localparam int NPORTS = 2;
    localparam int SLOT_W = 4;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [SLOT_W-1:0] req_slot [NREQ];
    logic [DATA_W-1:0] req_data [NREQ];
    logic [NREQ-1:0]   req_ready;
    logic [NPORTS-1:0] wr_valid;
    logic [SLOT_W-1:0] wr_slot [NPORTS];
    logic [DATA_W-1:0] wr_data [NPORTS];
`ifdef ROB_WB_ARB_STATS_EN
    logic [31:0]       stat_grants;
    logic [31:0]       stat_conflicts;
`endif

    int vectors;
    int miscompares;

    rob_wb_arbiter #(
        .NREQ(NREQ), .NPORTS(NPORTS), .SLOT_W(SLOT_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .req_valid(req_valid),
        .req_slot(req_slot),
        .req_data(req_data),
        .req_ready(req_ready),
        .wr_valid(wr_valid),
        .wr_slot(wr_slot),
        .wr_data(wr_data)
`ifdef ROB_WB_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        req_valid   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_slot[i] = '0;
            req_data[i] = '0;
        end
        step();
        step();
        reset = 1'b0;

        // Reset and idle
        check("rst_wr_slot0", 64'(wr_slot[0]), 64'd0);
        check("rst_wr_data1", 64'(wr_data[1]), 64'd0);
        for (int c = 0; c < 10; c++) begin
            check("idle_wr_valid", 64'(wr_valid), 64'd0);
            check("idle_req_ready", 64'(req_ready), 64'hF);
            step();
        end

        // Single transfer on requester 2
        req_valid   = 4'b0100;
        req_slot[2] = 4'd5;
        req_data[2] = 32'hDEAD_BEEF;
        step();
        req_valid = '0;
        check("single_c1_wr_valid", 64'(wr_valid), 64'd0);
        check("single_c1_ready", 64'(req_ready), 64'hF);
        step();
        check("single_c2_wr_valid", 64'(wr_valid), 64'b01);
        check("single_c2_slot0", 64'(wr_slot[0]), 64'd5);
        check("single_c2_data0", 64'(wr_data[0]), 64'hDEAD_BEEF);
        step();
        check("single_c3_wr_valid", 64'(wr_valid), 64'd0);

        // Reset mid-operation returns rr_ptr to 0, then 4-way burst
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_slot[i] = SLOT_W'(i);
            req_data[i] = 32'h100 + 32'(i);
        end
        step();
        req_valid = '0;
        check("burst_c1_ready", 64'(req_ready), 64'b0011);
        check("burst_c1_wr_valid", 64'(wr_valid), 64'd0);
        step();
        check("burst_c2_wr_valid", 64'(wr_valid), 64'b11);
        check("burst_c2_slot0", 64'(wr_slot[0]), 64'd0);
        check("burst_c2_slot1", 64'(wr_slot[1]), 64'd1);
        check("burst_c2_data1", 64'(wr_data[1]), 64'h101);
        check("burst_c2_ready", 64'(req_ready), 64'hF);
        step();
        check("burst_c3_wr_valid", 64'(wr_valid), 64'b11);
        check("burst_c3_slot0", 64'(wr_slot[0]), 64'd2);
        check("burst_c3_slot1", 64'(wr_slot[1]), 64'd3);
        check("burst_c3_data0", 64'(wr_data[0]), 64'h102);
        step();
        check("burst_c4_wr_valid", 64'(wr_valid), 64'd0);
        check("burst_c4_slot_hold", 64'(wr_slot[1]), 64'd3);
`ifdef ROB_WB_ARB_STATS_EN
        check("stat_grants_burst", 64'(stat_grants), 64'd4);
        check("stat_conflicts_burst", 64'(stat_conflicts), 64'd1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("idle_flush_wr_valid", 64'(wr_valid), 64'd0);
`ifdef ROB_WB_ARB_STATS_EN
        check("stat_grants_flush", 64'(stat_grants), 64'd4);
        check("stat_conflicts_flush", 64'(stat_conflicts), 64'd1);
`endif

        // rr_ptr back at 0: requester 0 must precede requester 3
        req_valid   = 4'b1001;
        req_slot[0] = 4'd7;
        req_data[0] = 32'h7777;
        req_slot[3] = 4'd8;
        req_data[3] = 32'h8888;
        step();
        req_valid = '0;
        step();
        check("rr_wr_valid", 64'(wr_valid), 64'b11);
        check("rr_port0_slot", 64'(wr_slot[0]), 64'd7);
        check("rr_port1_slot", 64'(wr_slot[1]), 64'd8);
        step();
        check("rr_after_wr_valid", 64'(wr_valid), 64'd0);
        check("rr_after_slot_hold", 64'(wr_slot[0]), 64'd7);

        // Requester 1 streams 8 results
        for (int i = 0; i < 8; i++) begin
            req_valid   = 4'b0010;
            req_slot[1] = SLOT_W'(i);
            req_data[1] = 32'hA0 + 32'(i);
            check("stream_ready1", 64'(req_ready[1]), 64'd1);
            step();
            if (i > 0) begin
                check("stream_wr_valid", 64'(wr_valid), 64'b01);
                check("stream_slot0", 64'(wr_slot[0]), 64'(i - 1));
                check("stream_data0", 64'(wr_data[0]), 64'hA0 + 64'(i - 1));
            end
        end
        req_valid = '0;
        step();
        check("stream_last_wr_valid", 64'(wr_valid), 64'b01);
        check("stream_last_slot0", 64'(wr_slot[0]), 64'd7);
        check("stream_last_data0", 64'(wr_data[0]), 64'hA7);
        step();
        check("stream_done_wr_valid", 64'(wr_valid), 64'd0);

        // Flush with buffers 0 and 3 full, requester 2 offering
        req_valid   = 4'b1001;
        req_slot[0] = 4'd1;
        req_slot[3] = 4'd2;
        step();
        req_valid   = 4'b0100;
        req_slot[2] = 4'd9;
        req_data[2] = 32'h5555_5555;
        flush       = 1'b1;
        check("flush_ready", 64'(req_ready), 64'hF);
        step();
        flush     = 1'b0;
        req_valid = '0;
        check("flush_c1_wr_valid", 64'(wr_valid), 64'd0);
        check("flush_c1_ready", 64'(req_ready), 64'hF);
        for (int c = 0; c < 3; c++) begin
            step();
            check("flush_drop_wr_valid", 64'(wr_valid), 64'd0);
        end
`ifdef ROB_WB_ARB_STATS_EN
        check("stat_grants_end", 64'(stat_grants), 64'd14);
        check("stat_conflicts_end", 64'(stat_conflicts), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
